rnic_exdes_write_pkt_gen: RTL and testbench
===========================================

// Module: rnic_exdes_write_pkt_gen
// PURPOSE
//  Example-design stimulus stage for the write-path test. Runs NUM_PKTS RoCE RDMA WRITE_ONLY packets
//  on a 512b AXIS master into the RNIC rx packet handler (rx_pkt_hndler_s_axis_*). In parallel it drives
//  write_pkt_psn to the write tx checker, which compares that PSN against the returned ACKs.
// PARAMETERS
//  C_AXIS_DATA_WIDTH  512    AXIS data width; only 512 supported
//  NUM_PKTS           16     packets per run, 1..255
//  PAYLOAD_BEATS      4      payload beats per packet, 1..63 (64 B each)
//  START_PSN          24'h0  PSN of first packet after reset
//  IPG_CYCLES         8      idle cycles (tvalid low) between packets, min 1
// PORTS
//  core_clk        in   1    clock
//  core_rst        in   1    synchronous reset, active high
//  start_i         in   1    1-cycle pulse: begin a run
//  dest_qp_i       in   24   destination QP, sampled at start
//  rkey_i          in   32   remote key, sampled at start
//  base_va_i       in   64   remote VA of first packet, sampled at start
//  m_axis_tdata    out  512  packet data
//  m_axis_tkeep    out  64   always all-ones while tvalid
//  m_axis_tvalid   out  1    AXIS valid
//  m_axis_tlast    out  1    last payload beat
//  m_axis_tready   in   1    AXIS ready
//  write_pkt_psn   out  24   PSN of current/last packet, to checker
//  pkt_sent_cnt    out  8    packets fully accepted this run
//  busy_o          out  1    run in progress
//  done_o          out  1    run complete; held until next start
// BEHAVIOUR
//  Reset: tvalid/tlast/busy_o/done_o=0, tdata=0, pkt_sent_cnt=0, write_pkt_psn=START_PSN, FSM=IDLE.
//  FSM: IDLE -start_i-> HDR -> PAYLOAD -> (GAP -> HDR | DONE); DONE -start_i-> HDR.
//  - start_i is honoured only in IDLE or DONE. It samples dest_qp_i, rkey_i and base_va_i, clears
//    pkt_sent_cnt and done_o, and sets busy_o.
//  - HDR: tvalid=1, tlast=0, header beat:
//    - [511:448] VA = base_va + n*PAYLOAD_BEATS*64
//    - [431:408] PSN; [407:384] dest QP; [383:352] rkey
//    - [343:336] opcode 8'h0A; [335:304] DMA length = PAYLOAD_BEATS*64
//    - all other bits 0
//  - PAYLOAD: PAYLOAD_BEATS beats of {512{1'b1}}; tlast=1 on the final beat only.
//  - A beat advances only on tvalid&&tready. While stalled, tdata/tlast are held stable and tvalid is
//    not dropped.
//  - When the last beat is accepted: pkt_sent_cnt+1. Go to DONE if pkt_sent_cnt+1==NUM_PKTS,
//    otherwise go to GAP.
//  - GAP: tvalid=0 for exactly IPG_CYCLES cycles. This guarantees a tvalid rising edge per packet,
//    which the checker's PSN FIFO write relies on.
//  - write_pkt_psn: updated on the cycle of HDR entry, i.e. the same cycle tvalid rises. Stable for
//    the whole packet and gap.
//    - First packet of a run uses the current PSN register; each later packet uses previous+1.
//    - PSN persists across runs; only reset reloads START_PSN.
//  - PSN arithmetic is mod 2^24: 24'hFFFFFF -> 24'h000000, no flag. VA add is mod 2^64.
//  - DONE: busy_o=0, done_o=1, tvalid=0.
//  - Reset mid-packet: outputs return to reset values next cycle; the partial packet is abandoned.
//  - Latency: start_i at cycle t -> tvalid=1 with header at t+1.
// CONFIGURATION
//  PKT_GEN_INCR_PATTERN_EN
//   - Defined: payload beat k of packet n = {16{n[15:0],k[15:0]}}.
//   - Undefined (default): payload = {512{1'b1}}, which the read-response data check expects.
//   - Header and timing are identical either way.
// TESTING
//  1. Reset, START_PSN=0, NUM_PKTS=4, PAYLOAD_BEATS=2, tready=1, start
//     -> 4 pkts of 3 beats, PSNs 0..3, tlast on beat 3, 8 idle cycles between pkts,
//        pkt_sent_cnt=4, done_o=1.
//  2. tready toggled 1/0 every cycle -> beat content unchanged across stalls, tvalid never drops
//     mid-packet, same 4 PSNs in order.
//  3. START_PSN=24'hFFFFFE, NUM_PKTS=4 -> PSNs FFFFFE, FFFFFF, 000000, 000001.
//  4. base_va=64'h1000, PAYLOAD_BEATS=4 -> VAs 1000, 1100, 1200, ...; length field 32'h100;
//     opcode 0A; dest QP/rkey match inputs.
//  5. start_i pulsed while busy -> ignored. Core_rst asserted mid-payload -> tvalid=0 next cycle,
//     write_pkt_psn=START_PSN, busy_o=0.
//  6. Second run after done -> PSN continues from last+1; pkt_sent_cnt restarts at 0.

Source files
------------

// File: rtl/rnic_exdes_write_pkt_gen_if.sv
// AXI-Stream bus carrying generated RoCE WRITE_ONLY packets into the rx packet handler.
interface rnic_exdes_write_pkt_gen_if #(
  parameter int DATA_W = 512
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tvalid;
  logic                tlast;
  logic                tready;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/rnic_exdes_write_pkt_gen.sv
// RDMA WRITE_ONLY packet generator for the write-path example design (header beat + payload beats).
// Optional macro PKT_GEN_INCR_PATTERN_EN selects an incrementing payload instead of all-ones.
module rnic_exdes_write_pkt_gen #(
  parameter int          C_AXIS_DATA_WIDTH = 512,
  parameter int          NUM_PKTS          = 16,
  parameter int          PAYLOAD_BEATS     = 4,
  parameter logic [23:0] START_PSN         = 24'h0,
  parameter int          IPG_CYCLES        = 8
) (
  input  logic        core_clk,
  input  logic        core_rst,
  input  logic        start_i,
  input  logic [23:0] dest_qp_i,
  input  logic [31:0] rkey_i,
  input  logic [63:0] base_va_i,
  rnic_exdes_write_pkt_gen_if.master m_axis,
  output logic [23:0] write_pkt_psn,
  output logic [7:0]  pkt_sent_cnt,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [31:0] DMA_LEN = 32'(PAYLOAD_BEATS * 64);
  localparam logic [63:0] VA_STEP = 64'(PAYLOAD_BEATS * 64);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, GAP, DONE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  beat_cnt;
  logic [15:0] gap_cnt;
  logic        psn_used;
  logic [23:0] dest_qp;
  logic [31:0] rkey;
  logic [63:0] va;
  logic        start_ok, last_beat, run_done, gap_end, hdr_entry;

  function automatic logic [C_AXIS_DATA_WIDTH-1:0] build_hdr(
    input logic [63:0] hva, input logic [23:0] hpsn,
    input logic [23:0] hqp, input logic [31:0] hrkey);
    logic [C_AXIS_DATA_WIDTH-1:0] h;
    h            = '0;
    h[511:448]   = hva;
    h[431:408]   = hpsn;
    h[407:384]   = hqp;
    h[383:352]   = hrkey;
    h[343:336]   = 8'h0A;
    h[335:304]   = DMA_LEN;
    return h;
  endfunction

  function automatic logic [C_AXIS_DATA_WIDTH-1:0] build_payload(
    input logic [7:0] pkt_idx, input logic [5:0] beat_idx);
`ifdef PKT_GEN_INCR_PATTERN_EN
    return {16{8'h00, pkt_idx, 10'h000, beat_idx}};
`else
    logic unused;
    unused = ^{pkt_idx, beat_idx};
    return {C_AXIS_DATA_WIDTH{1'b1}};
`endif
  endfunction

  assign start_ok  = start_i && (state == IDLE || state == DONE);
  assign last_beat = (beat_cnt == 6'(PAYLOAD_BEATS - 1));
  assign run_done  = ((pkt_sent_cnt + 8'd1) == 8'(NUM_PKTS));
  assign gap_end   = (gap_cnt == 16'(IPG_CYCLES - 1));
  assign hdr_entry = (state_nxt == HDR) && (state != HDR);

  always_comb begin
    state_nxt     = state;
    m_axis.tvalid = 1'b0;
    m_axis.tlast  = 1'b0;
    m_axis.tkeep  = '0;
    m_axis.tdata  = '0;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    case (state)
      IDLE: if (start_i) state_nxt = HDR;
      HDR: begin
        m_axis.tvalid = 1'b1;
        m_axis.tkeep  = '1;
        m_axis.tdata  = build_hdr(va, write_pkt_psn, dest_qp, rkey);
        busy_o        = 1'b1;
        if (m_axis.tready) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        m_axis.tvalid = 1'b1;
        m_axis.tkeep  = '1;
        m_axis.tlast  = last_beat;
        m_axis.tdata  = build_payload(pkt_sent_cnt, beat_cnt);
        busy_o        = 1'b1;
        if (m_axis.tready && last_beat) state_nxt = run_done ? DONE : GAP;
      end
      GAP: begin
        busy_o = 1'b1;
        if (gap_end) state_nxt = HDR;
      end
      DONE: begin
        done_o = 1'b1;
        if (start_i) state_nxt = HDR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: the first header after reset reuses START_PSN, every later header bumps it.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      gap_cnt       <= '0;
      pkt_sent_cnt  <= '0;
      write_pkt_psn <= START_PSN;
      psn_used      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok)
        pkt_sent_cnt <= '0;
      else if (state == PAYLOAD && m_axis.tready && last_beat)
        pkt_sent_cnt <= pkt_sent_cnt + 8'd1;
      if (state == HDR)
        beat_cnt <= '0;
      else if (state == PAYLOAD && m_axis.tready)
        beat_cnt <= beat_cnt + 6'd1;
      gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : '0;
      if (hdr_entry) begin
        if (psn_used) write_pkt_psn <= write_pkt_psn + 24'd1;
        psn_used <= 1'b1;
      end
    end
  end

  // Run parameters are data only; they are always loaded by start before use.
  always_ff @(posedge core_clk) begin
    if (start_ok) begin
      dest_qp <= dest_qp_i;
      rkey    <= rkey_i;
      va      <= base_va_i;
    end else if (state == GAP && gap_end) begin
      va <= va + VA_STEP;
    end
  end

endmodule

// File: tb/tb_rnic_exdes_write_pkt_gen.sv
// Scoreboard bench for the write packet generator: expected beats queued at start, checked on the bus.
module tb_rnic_exdes_write_pkt_gen;

  localparam int          NUM_PKTS      = 4;
  localparam int          PAYLOAD_BEATS = 2;
  localparam logic [23:0] START_PSN     = 24'hFFFFFE;
  localparam int          IPG_CYCLES    = 8;

  typedef struct {
    logic [511:0] data;
    logic         last;
    logic [23:0]  psn;
  } beat_t;

  logic        core_clk, core_rst, start_i;
  logic [23:0] dest_qp_i;
  logic [31:0] rkey_i;
  logic [63:0] base_va_i;
  logic [23:0] write_pkt_psn;
  logic [7:0]  pkt_sent_cnt;
  logic        busy_o, done_o;
  logic        tog;

  int    n_chk = 0;
  int    n_bad = 0;
  beat_t q[$];
  logic [23:0] m_psn;
  logic        m_used;
  bit          in_pkt, gap_on;
  int          gap_cnt;

  rnic_exdes_write_pkt_gen_if #(.DATA_W(512)) axis ();

  rnic_exdes_write_pkt_gen #(
    .C_AXIS_DATA_WIDTH(512), .NUM_PKTS(NUM_PKTS), .PAYLOAD_BEATS(PAYLOAD_BEATS),
    .START_PSN(START_PSN), .IPG_CYCLES(IPG_CYCLES)
  ) dut (
    .core_clk(core_clk), .core_rst(core_rst), .start_i(start_i),
    .dest_qp_i(dest_qp_i), .rkey_i(rkey_i), .base_va_i(base_va_i),
    .m_axis(axis), .write_pkt_psn(write_pkt_psn), .pkt_sent_cnt(pkt_sent_cnt),
    .busy_o(busy_o), .done_o(done_o)
  );

  initial begin
    core_clk = 1'b0;
    forever #5 core_clk = ~core_clk;
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] exp_hdr(input logic [63:0] va, input logic [23:0] psn,
                                           input logic [23:0] qp, input logic [31:0] rkey);
    logic [511:0] h;
    h = '0;
    h[511:448] = va;
    h[431:408] = psn;
    h[407:384] = qp;
    h[383:352] = rkey;
    h[343:336] = 8'h0A;
    h[335:304] = 32'(PAYLOAD_BEATS * 64);
    return h;
  endfunction

  function automatic logic [511:0] exp_payload(input int n, input int k);
`ifdef PKT_GEN_INCR_PATTERN_EN
    logic [31:0] w;
    w = {16'(n), 16'(k)};
    return {16{w}};
`else
    return {512{1'b1}};
`endif
  endfunction

  // tready: always high, or toggled every cycle when tog is set
  initial begin
    axis.tready = 1'b1;
    forever begin
      @(posedge core_clk);
      #1;
      axis.tready = tog ? ~axis.tready : 1'b1;
    end
  end

  // Bus monitor against the scoreboard
  always @(negedge core_clk) begin
    if (core_rst) begin
      q.delete();
      in_pkt  = 0;
      gap_on  = 0;
      gap_cnt = 0;
    end else begin
      if (done_o) gap_on = 0;
      if (axis.tvalid) begin
        if (!in_pkt && gap_on) begin
          check("gap_len", 512'(gap_cnt), 512'(IPG_CYCLES));
          gap_on = 0;
        end
        in_pkt = 1;
        check("tkeep", 512'(axis.tkeep), 512'({64{1'b1}}));
        if (q.size() == 0) begin
          check("extra_beat", 512'(1), 512'(0));
        end else begin
          check("tdata", axis.tdata, q[0].data);
          check("tlast", 512'(axis.tlast), 512'(q[0].last));
          check("psn_out", 512'(write_pkt_psn), 512'(q[0].psn));
          if (axis.tready) begin
            if (q[0].last) begin
              in_pkt  = 0;
              gap_on  = 1;
              gap_cnt = 0;
            end
            void'(q.pop_front());
          end
        end
      end else begin
        if (in_pkt) check("mid_vld", 512'(axis.tvalid), 512'(1));
        if (gap_on) gap_cnt++;
      end
    end
  end

  task automatic push_run(input logic [23:0] qp, input logic [31:0] rk, input logic [63:0] va);
    beat_t b;
    for (int n = 0; n < NUM_PKTS; n++) begin
      if (m_used) m_psn = m_psn + 24'd1;
      m_used = 1'b1;
      b.psn  = m_psn;
      b.data = exp_hdr(va + 64'(n * PAYLOAD_BEATS * 64), m_psn, qp, rk);
      b.last = 1'b0;
      q.push_back(b);
      for (int k = 0; k < PAYLOAD_BEATS; k++) begin
        b.data = exp_payload(n, k);
        b.last = (k == PAYLOAD_BEATS - 1);
        q.push_back(b);
      end
    end
  endtask

  task automatic do_start(input logic [23:0] qp, input logic [31:0] rk, input logic [63:0] va);
    logic [23:0] first_psn;
    @(posedge core_clk);
    #1;
    start_i   = 1'b1;
    dest_qp_i = qp;
    rkey_i    = rk;
    base_va_i = va;
    first_psn = m_used ? m_psn + 24'd1 : m_psn;
    push_run(qp, rk, va);
    @(posedge core_clk);
    #1;
    start_i = 1'b0;
    @(negedge core_clk);
    check("lat_tvalid", 512'(axis.tvalid), 512'(1));
    check("lat_psn", 512'(write_pkt_psn), 512'(first_psn));
    check("start_cnt", 512'(pkt_sent_cnt), 512'(0));
    check("start_busy", 512'(busy_o), 512'(1));
    check("start_done", 512'(done_o), 512'(0));
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge core_clk);
      if (done_o) seen = 1;
    end
    check({tag, "_done"}, 512'(done_o), 512'(1));
    check({tag, "_cnt"}, 512'(pkt_sent_cnt), 512'(NUM_PKTS));
    check({tag, "_busy"}, 512'(busy_o), 512'(0));
    check({tag, "_sb_empty"}, 512'(q.size()), 512'(0));
  endtask

  initial begin
    core_rst  = 1'b1;
    start_i   = 1'b0;
    dest_qp_i = '0;
    rkey_i    = '0;
    base_va_i = '0;
    tog       = 1'b0;
    m_psn     = START_PSN;
    m_used    = 1'b0;
    repeat (3) @(posedge core_clk);
    @(negedge core_clk);
    check("rst_tvalid", 512'(axis.tvalid), 512'(0));
    check("rst_tlast", 512'(axis.tlast), 512'(0));
    check("rst_tdata", axis.tdata, 512'(0));
    check("rst_psn", 512'(write_pkt_psn), 512'(START_PSN));
    check("rst_cnt", 512'(pkt_sent_cnt), 512'(0));
    check("rst_busy", 512'(busy_o), 512'(0));
    check("rst_done", 512'(done_o), 512'(0));
    @(posedge core_clk);
    #1;
    core_rst = 1'b0;

    // Run 1: full throughput, PSN wrap FFFFFE..000001
    do_start(24'h123456, 32'hCAFEBABE, 64'h1000);
    wait_done("run1");
    check("run1_last_psn", 512'(write_pkt_psn), 512'(24'h000001));

    // Run 2: stalled bus, stray start while busy, PSN continues from last+1
    tog = 1'b1;
    do_start(24'h00ABCD, 32'h11223344, 64'hFFFF_FFFF_FFFF_FF80);
    repeat (10) @(posedge core_clk);
    #1;
    start_i   = 1'b1;
    dest_qp_i = 24'h777777;
    base_va_i = 64'h0;
    @(posedge core_clk);
    #1;
    start_i = 1'b0;
    wait_done("run2");
    check("run2_last_psn", 512'(write_pkt_psn), 512'(24'h000005));
    tog = 1'b0;

    // Run 3: reset asserted during the first payload beat
    do_start(24'h000042, 32'h0BADF00D, 64'h2000);
    @(posedge core_clk);
    #1;
    core_rst = 1'b1;
    @(posedge core_clk);
    @(negedge core_clk);
    check("midrst_tvalid", 512'(axis.tvalid), 512'(0));
    check("midrst_psn", 512'(write_pkt_psn), 512'(START_PSN));
    check("midrst_busy", 512'(busy_o), 512'(0));
    check("midrst_cnt", 512'(pkt_sent_cnt), 512'(0));
    m_psn  = START_PSN;
    m_used = 1'b0;
    @(posedge core_clk);
    #1;
    core_rst = 1'b0;

    // Run 4: clean run after reset restarts at START_PSN
    do_start(24'hFEDCBA, 32'h89ABCDEF, 64'h1_0000_0000);
    wait_done("run4");
    check("run4_last_psn", 512'(write_pkt_psn), 512'(24'h000001));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
